// File: rtl/ram_block_copier_if.sv
// ram_block_copier_if
//   Bundles the CPU-side control signals and the RAM4K memory port used by
//   the block copier.
//   master modport: the copier (drives the memory port, busy and done).
//   slave modport : the surrounding system (control registers plus RAM4K).
// Signals
//   start, abort       copy request / cancel
//   src, dst, len      copy parameters, captured on start
//   mem_address/in     RAM address and write data
//   mem_load           RAM write enable
//   mem_out            RAM combinational read data
//   busy, done         copier status
interface ram_block_copier_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, src, dst, len, mem_out,
    output mem_address, mem_in, mem_load, busy, done
  );

  modport slave (
    output start, abort, src, dst, len, mem_out,
    input  mem_address, mem_in, mem_load, busy, done
  );
endinterface

// File: rtl/ram_block_copier.sv
// ram_block_copier
//   Bus master for the single-port RAM4K data memory. Copies len words from
//   src to dst one word at a time: a READ cycle latches the source word, a
//   WRITE cycle stores it at the destination. Copy order is strictly
//   ascending and addresses wrap modulo 2**ADDR_W.
// Ports
//   clk      rising-edge clock shared with RAM4K
//   reset_n  asynchronous active-low reset
//   bus      master side of ram_block_copier_if (control + memory port)
module ram_block_copier #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram_block_copier_if.master    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   idx_inc;
  logic [DATA_W-1:0] data_q;

  assign idx_inc = idx_q + {{ADDR_W{1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode. Address sums are ADDR_W bits wide
  // so they wrap naturally past the top of memory. Abort beats the normal
  // WRITE exit; the word being written in that cycle still commits because
  // mem_load is already high.
  always_comb begin
    state_d         = state_q;
    bus.mem_address = '0;
    bus.mem_in      = '0;
    bus.mem_load    = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == '0) ? DONE : READ;
        end
      end
      READ: begin
        bus.busy        = 1'b1;
        bus.mem_address = src_q + idx_q[ADDR_W-1:0];
        state_d         = bus.abort ? IDLE : WRITE;
      end
      WRITE: begin
        bus.busy        = 1'b1;
        bus.mem_address = dst_q + idx_q[ADDR_W-1:0];
        bus.mem_in      = data_q;
        bus.mem_load    = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_inc == len_q) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Copy parameters are captured only when a start is accepted in IDLE, so
  // later changes on src/dst/len cannot disturb a running copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            src_q <= bus.src;
            dst_q <= bus.dst;
            len_q <= bus.len;
            idx_q <= '0;
          end
        end
        READ:    data_q <= bus.mem_out;
        WRITE:   idx_q  <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_copier.sv
// tb_ram_block_copier
//   Self-checking bench for ram_block_copier. Holds a behavioural RAM4K and
//   a reference memory image updated by a plain ascending word-copy loop.
module tb_ram_block_copier;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk;
  logic reset_n;

  ram_block_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_block_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM4K with a bench-side preload port
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;

  assign bus.mem_out = ram[bus.mem_address];

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;
  end

  int errors;
  int checks;

  // Results of the most recent run_copy
  int            done_cycle;
  int            done_count;
  int            busy_cycles;
  int            load_cycles;
  bit            finished;
  logic [AW-1:0] read_log [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words(input logic [AW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      tb_we   = 1'b1;
      tb_addr = base + AW'(k);
      tb_data = DW'($urandom);
      ref_mem[tb_addr] = tb_data;
      step();
    end
    tb_we = 1'b0;
  endtask

  // Reference copy: plain ascending word loop with wrapping addresses
  function automatic void ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      ref_mem[d + AW'(k)] = ref_mem[s + AW'(k)];
    end
  endfunction

  function automatic int count_mem_diffs(output int first_addr);
    int n;
    n = 0;
    first_addr = -1;
    for (int a = 0; a < 4096; a++) begin
      if (ram[a] !== ref_mem[a]) begin
        if (n == 0) first_addr = a;
        n++;
      end
    end
    return n;
  endfunction

  // Issues a start and observes the copy until busy falls. Optionally holds
  // abort together with start, or re-pulses start at mid_cycle.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int n, input bit abort_with_start, input int mid_cycle);
    int budget;
    budget      = 2 * n + 10;
    done_cycle  = -1;
    done_count  = 0;
    busy_cycles = 0;
    load_cycles = 0;
    finished    = 1'b0;
    read_log.delete();
    bus.start = 1'b1;
    bus.abort = abort_with_start;
    bus.src   = s;
    bus.dst   = d;
    bus.len   = (AW+1)'(n);
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src   = AW'($urandom);
    bus.dst   = AW'($urandom);
    bus.len   = (AW+1)'($urandom_range(1, 4096));
    for (int c = 1; c <= budget; c++) begin
      if (bus.busy) busy_cycles++;
      if (bus.mem_load) load_cycles++;
      if (bus.done) begin
        done_count++;
        done_cycle = c;
      end
      if (bus.busy && !bus.mem_load && !bus.done) read_log.push_back(bus.mem_address);
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
      if (c == mid_cycle) begin
        bus.start = 1'b1;
        bus.src   = s + 12'h123;
        bus.dst   = d + 12'h321;
        bus.len   = 13'd2;
      end
      step();
      bus.start = 1'b0;
    end
    ref_copy(s, d, n);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
    tb_we     = 1'b0;
    tb_addr   = '0;
    tb_data   = '0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = ram[a];
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b load=%b expected 0 0 0", bus.busy, bus.done, bus.mem_load);
    end
    checks++;
    if (bus.mem_address !== 12'h000 || bus.mem_in !== 16'h0000) begin
      errors++;
      $display("FAIL reset_port: addr=%h in=%h expected 000 0000", bus.mem_address, bus.mem_in);
    end
    reset_n = 1'b1;
    step();
    bus.abort = 1'b1;
    step();
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic_copy();
    int diffs, first;
    fill_words(12'h010, 4);
    fill_words(12'h200, 4);
    run_copy(12'h010, 12'h200, 4, 1'b0, 0);
    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL basic_timeout: finished=%b expected 1", finished);
    end
    checks++;
    if (done_cycle !== 9 || done_count !== 1) begin
      errors++;
      $display("FAIL basic_done: cycle=%0d count=%0d expected cycle 9 count 1", done_cycle, done_count);
    end
    checks++;
    if (busy_cycles !== 9 || load_cycles !== 4) begin
      errors++;
      $display("FAIL basic_busy_load: busy=%0d load=%0d expected 9 4", busy_cycles, load_cycles);
    end
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL basic_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic test_zero_len();
    int diffs, first;
    run_copy(12'h055, 12'h300, 0, 1'b0, 0);
    checks++;
    if (done_cycle !== 1 || done_count !== 1 || busy_cycles !== 1) begin
      errors++;
      $display("FAIL zero_done: cycle=%0d count=%0d busy=%0d expected 1 1 1", done_cycle, done_count, busy_cycles);
    end
    checks++;
    if (load_cycles !== 0) begin
      errors++;
      $display("FAIL zero_load: load=%0d expected 0", load_cycles);
    end
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL zero_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic test_wrap();
    int diffs, first;
    fill_words(12'hFFE, 3);
    fill_words(12'h100, 3);
    run_copy(12'hFFE, 12'h100, 3, 1'b0, 0);
    checks++;
    if (read_log.size() !== 3) begin
      errors++;
      $display("FAIL wrap_reads: count=%0d expected 3", read_log.size());
    end else if (read_log[0] !== 12'hFFE || read_log[1] !== 12'hFFF || read_log[2] !== 12'h000) begin
      errors++;
      $display("FAIL wrap_reads: addrs=%h %h %h expected ffe fff 000", read_log[0], read_log[1], read_log[2]);
    end
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL wrap_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic test_abort();
    int diffs, first, pulses;
    fill_words(12'h400, 4);
    fill_words(12'h480, 4);
    bus.start = 1'b1;
    bus.src   = 12'h400;
    bus.dst   = 12'h480;
    bus.len   = 13'd4;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    checks++;
    if (bus.mem_load !== 1'b1) begin
      errors++;
      $display("FAIL abort_second_write: load=%b expected 1", bus.mem_load);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done || bus.mem_load) pulses++;
      step();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_quiet: activity cycles=%0d expected 0", pulses);
    end
    ref_copy(12'h400, 12'h480, 2);
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL abort_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic test_start_with_abort();
    int diffs, first;
    fill_words(12'h500, 2);
    run_copy(12'h500, 12'h600, 2, 1'b1, 0);
    checks++;
    if (done_cycle !== 5 || done_count !== 1 || load_cycles !== 2) begin
      errors++;
      $display("FAIL start_abort: done=%0d count=%0d load=%0d expected 5 1 2", done_cycle, done_count, load_cycles);
    end
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL start_abort_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic test_back_to_back();
    int diffs, first;
    fill_words(12'h700, 4);
    run_copy(12'h700, 12'h740, 4, 1'b0, 3);
    checks++;
    if (done_cycle !== 9 || busy_cycles !== 9 || load_cycles !== 4) begin
      errors++;
      $display("FAIL restart_ignored: done=%0d busy=%0d load=%0d expected 9 9 4", done_cycle, busy_cycles, load_cycles);
    end
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL restart_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
  endtask

  task automatic test_async_reset();
    int diffs, first;
    fill_words(12'h800, 4);
    bus.start = 1'b1;
    bus.src   = 12'h800;
    bus.dst   = 12'h900;
    bus.len   = 13'd4;
    step();
    bus.start = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_load !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: load=%b busy=%b done=%b expected 0 0 0", bus.mem_load, bus.busy, bus.done);
    end
    #1;
    reset_n = 1'b1;
    step();
    diffs = count_mem_diffs(first);
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL async_reset_mem: %0d words differ, first at %h ram=%h expected %h", diffs, first, ram[first], ref_mem[first]);
    end
    run_copy(12'h800, 12'h900, 1, 1'b0, 0);
    checks++;
    if (done_cycle !== 3 || busy_cycles !== 3 || load_cycles !== 1) begin
      errors++;
      $display("FAIL after_reset_copy: done=%0d busy=%0d load=%0d expected 3 3 1", done_cycle, busy_cycles, load_cycles);
    end
  endtask

  task automatic test_random();
    int diffs, first, n, mode;
    logic [AW-1:0] s, d;
    for (int it = 0; it < 8; it++) begin
      s    = AW'($urandom);
      n    = $urandom_range(1, 10);
      mode = $urandom_range(0, 2);
      if (mode == 0) d = AW'($urandom);
      else if (mode == 1) d = s + AW'($urandom_range(1, 3));
      else d = s - AW'($urandom_range(1, 3));
      fill_words(s, n);
      if (mode == 0) fill_words(d, n);
      run_copy(s, d, n, 1'b0, 0);
      checks++;
      if (done_cycle !== 2 * n + 1 || busy_cycles !== 2 * n + 1 || load_cycles !== n) begin
        errors++;
        $display("FAIL random_timing: src=%h dst=%h len=%0d done=%0d busy=%0d load=%0d expected %0d %0d %0d",
                 s, d, n, done_cycle, busy_cycles, load_cycles, 2 * n + 1, 2 * n + 1, n);
      end
      diffs = count_mem_diffs(first);
      checks++;
      if (diffs !== 0) begin
        errors++;
        $display("FAIL random_mem: src=%h dst=%h len=%0d, %0d words differ, first at %h ram=%h expected %h",
                 s, d, n, diffs, first, ram[first], ref_mem[first]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_wrap();
    test_abort();
    test_start_with_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
